// File: rtl/gpr_scoreboard_if.sv
// Issue-side, operand-fetch-side and writeback signals of one GPR scoreboard slice.
// The slave modport is the scoreboard's view, and the master modport is its environment's view.
interface gpr_scoreboard_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int PAYLOAD_W = 128
);
  localparam int WIS_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS = $clog2(NUM_REGS);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIS_W-1:0]     in_wis;
  logic                 in_wb;
  logic [NR_BITS-1:0]   in_rd;
  logic [NR_BITS-1:0]   in_rs1;
  logic [NR_BITS-1:0]   in_rs2;
  logic [NR_BITS-1:0]   in_rs3;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIS_W-1:0]     out_wis;
  logic                 out_wb;
  logic [NR_BITS-1:0]   out_rd;
  logic [NR_BITS-1:0]   out_rs1;
  logic [NR_BITS-1:0]   out_rs2;
  logic [NR_BITS-1:0]   out_rs3;
  logic [PAYLOAD_W-1:0] out_payload;

  logic                 wb_valid;
  logic [WIS_W-1:0]     wb_wis;
  logic [NR_BITS-1:0]   wb_rd;
  logic                 wb_eop;

  modport slave (
    input  in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_payload,
    output in_ready,
    output out_valid, out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_payload,
    input  out_ready,
    input  wb_valid, wb_wis, wb_rd, wb_eop
  );

  modport master (
    output in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_payload,
    input  in_ready,
    input  out_valid, out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_payload,
    output out_ready,
    output wb_valid, wb_wis, wb_rd, wb_eop
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-warp register hazard scoreboard feeding a registered one-entry elastic stage to operand fetch.
// It reserves rd when an instruction is accepted and frees rd on the final writeback packet.
module gpr_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int PAYLOAD_W = 128,
  parameter int PERF_W    = 44
) (
  input  logic              clk,
  input  logic              reset,
  gpr_scoreboard_if.slave   bus,
  output logic [PERF_W-1:0] stall_cycles
);

  logic [NUM_REGS-1:0]  inuse [NUM_WARPS];
  logic [NUM_REGS-1:0]  clear_mask;
  logic [NUM_REGS-1:0]  eff_row;
  logic                 wb_release;
  logic                 hazard;
  logic                 fire_in;
  logic                 fire_out;
  logic                 reserve;
  logic                 out_valid_q;
  logic [PAYLOAD_W-1:0] payload_q;

  assign wb_release = bus.wb_valid && bus.wb_eop;

  // A release landing this cycle on the presented warp unblocks it immediately
  always_comb begin
    clear_mask = '0;
    if (wb_release && (bus.wb_wis == bus.in_wis))
      clear_mask[bus.wb_rd] = 1'b1;
    eff_row    = inuse[bus.in_wis] & ~clear_mask;
    eff_row[0] = 1'b0;
    hazard     = eff_row[bus.in_rs1] || eff_row[bus.in_rs2] || eff_row[bus.in_rs3] ||
                 (bus.in_wb && eff_row[bus.in_rd]);
  end

  assign bus.in_ready    = !hazard && (!out_valid_q || bus.out_ready);
  assign fire_in         = bus.in_valid && bus.in_ready;
  assign fire_out        = out_valid_q && bus.out_ready;
  assign reserve         = fire_in && bus.in_wb && (bus.in_rd != '0);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_payload = payload_q;

  // The reservation is written after the clear, so a same-cycle set of the same bit wins
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++)
        inuse[w] <= '0;
    end else begin
      if (wb_release)
        inuse[bus.wb_wis][bus.wb_rd] <= 1'b0;
      if (reserve)
        inuse[bus.in_wis][bus.in_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      out_valid_q <= 1'b0;
    else if (fire_in)
      out_valid_q <= 1'b1;
    else if (fire_out)
      out_valid_q <= 1'b0;
  end

  // The data fields need no reset because out_valid qualifies them
  always_ff @(posedge clk) begin
    if (fire_in) begin
      bus.out_wis <= bus.in_wis;
      bus.out_wb  <= bus.in_wb;
      bus.out_rd  <= bus.in_rd;
      bus.out_rs1 <= bus.in_rs1;
      bus.out_rs2 <= bus.in_rs2;
      bus.out_rs3 <= bus.in_rs3;
      payload_q   <= bus.in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (bus.in_valid && hazard)
      stall_cycles <= stall_cycles + 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && wb_release)
      assert (inuse[bus.wb_wis][bus.wb_rd])
      else $error("gpr_scoreboard: writeback to unreserved register warp=%0d rd=%0d",
                  bus.wb_wis, bus.wb_rd);
  end
`endif

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard that uses a reference model of the reservation bits and stall counter.
// It also uses a queue scoreboard of expected output instructions.
module tb_gpr_scoreboard;
  localparam int NUM_WARPS = 4;
  localparam int NUM_REGS  = 64;
  localparam int PAYLOAD_W = 128;
  localparam int PERF_W    = 44;
  localparam int WIS_W     = 2;
  localparam int NR_BITS   = 6;

  typedef struct packed {
    logic [WIS_W-1:0]     wis;
    logic                 wb;
    logic [NR_BITS-1:0]   rd;
    logic [NR_BITS-1:0]   rs1;
    logic [NR_BITS-1:0]   rs2;
    logic [NR_BITS-1:0]   rs3;
    logic [PAYLOAD_W-1:0] payload;
  } item_t;

  logic              clk;
  logic              reset;
  logic [PERF_W-1:0] stall_cycles;

  gpr_scoreboard_if #(.NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS), .PAYLOAD_W(PAYLOAD_W)) bus ();

  gpr_scoreboard #(
    .NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS), .PAYLOAD_W(PAYLOAD_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [NUM_REGS-1:0] m_inuse [NUM_WARPS];
  logic                m_out_valid;
  logic [PERF_W-1:0]   m_stall;
  item_t               sb [$];

  logic              last_ready;
  logic              last_out_valid;
  logic [NR_BITS-1:0] last_out_rd;
  logic [NR_BITS-1:0] last_out_rs1;
  logic [PERF_W-1:0] last_stall;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic model_busy(input logic [NR_BITS-1:0] r);
    logic rel_hit;
    rel_hit = bus.wb_valid && bus.wb_eop && (bus.wb_wis == bus.in_wis) && (bus.wb_rd == r);
    return (r != '0) && m_inuse[bus.in_wis][r] && !rel_hit;
  endfunction

  task automatic present(input logic v, input logic [WIS_W-1:0] wis, input logic wb,
                         input logic [NR_BITS-1:0] rd, input logic [NR_BITS-1:0] rs1,
                         input logic [NR_BITS-1:0] rs2, input logic [NR_BITS-1:0] rs3);
    bus.in_valid   = v;
    bus.in_wis     = wis;
    bus.in_wb      = wb;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rs3     = rs3;
    bus.in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive_wb(input logic v, input logic [WIS_W-1:0] wis,
                          input logic [NR_BITS-1:0] rd, input logic eop);
    bus.wb_valid = v;
    bus.wb_wis   = wis;
    bus.wb_rd    = rd;
    bus.wb_eop   = eop;
  endtask

  // Sample mid-cycle, compare against the model, then advance the model across the coming edge
  task automatic tick();
    logic  exp_hazard, exp_ready, fire_in_m, fire_out_m;
    item_t cur, in_item;
    @(negedge clk);
    exp_hazard = model_busy(bus.in_rs1) || model_busy(bus.in_rs2) || model_busy(bus.in_rs3) ||
                 (bus.in_wb && model_busy(bus.in_rd));
    exp_ready  = !exp_hazard && (!m_out_valid || bus.out_ready);
    fire_in_m  = bus.in_valid && exp_ready;
    fire_out_m = m_out_valid && bus.out_ready;
    cur     = '{bus.out_wis, bus.out_wb, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_rs3,
                bus.out_payload};
    in_item = '{bus.in_wis, bus.in_wb, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_rs3,
                bus.in_payload};
    check("in_ready", 192'(bus.in_ready), 192'(exp_ready));
    check("out_valid", 192'(bus.out_valid), 192'(m_out_valid));
    check("stall_cycles", 192'(stall_cycles), 192'(m_stall));
    if (fire_out_m) begin
      check("sb_depth", 192'(sb.size()), 192'(1));
      if (sb.size() > 0) check("out_item", 192'(cur), 192'(sb.pop_front()));
    end else if (m_out_valid && sb.size() > 0) begin
      check("held_item", 192'(cur), 192'(sb[0]));
    end
    last_ready     = bus.in_ready;
    last_out_valid = bus.out_valid;
    last_out_rd    = bus.out_rd;
    last_out_rs1   = bus.out_rs1;
    last_stall     = stall_cycles;
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) m_inuse[w] = '0;
      m_out_valid = 1'b0;
      m_stall     = '0;
      sb.delete();
    end else begin
      if (bus.in_valid && exp_hazard) m_stall = m_stall + 1'b1;
      if (bus.wb_valid && bus.wb_eop) m_inuse[bus.wb_wis][bus.wb_rd] = 1'b0;
      if (fire_in_m && bus.in_wb && bus.in_rd != '0) m_inuse[bus.in_wis][bus.in_rd] = 1'b1;
      if (fire_in_m) sb.push_back(in_item);
      if (fire_in_m) m_out_valid = 1'b1;
      else if (fire_out_m) m_out_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int w = 0; w < NUM_WARPS; w++) m_inuse[w] = '0;
    m_out_valid   = 1'b0;
    m_stall       = '0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    present(0, 0, 0, 0, 0, 0, 0);
    drive_wb(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_out_valid", 192'(last_out_valid), 192'(0));
    check("rst_stall", 192'(last_stall), 192'(0));

    // Accept with reservation of rd=7
    present(1, 0, 1, 7, 5, 6, 0);
    tick();
    check("t1_ready", 192'(last_ready), 192'(1));
    present(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("t1_out_valid", 192'(last_out_valid), 192'(1));
    check("t1_out_rd", 192'(last_out_rd), 192'(7));

    // RAW on rd=7; a non-eop packet keeps the stall, and the eop packet bypasses it
    present(1, 0, 0, 0, 7, 0, 0);
    tick();
    check("t2_raw_stall", 192'(last_ready), 192'(0));
    tick();
    check("t2_stall_count", 192'(last_stall), 192'(1));
    drive_wb(1, 0, 7, 0);
    tick();
    check("t2_non_eop", 192'(last_ready), 192'(0));
    drive_wb(1, 0, 7, 1);
    tick();
    check("t2_bypass", 192'(last_ready), 192'(1));
    drive_wb(0, 0, 0, 0);
    present(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("t2_out_valid", 192'(last_out_valid), 192'(1));
    check("t2_out_rs1", 192'(last_out_rs1), 192'(7));

    // WAW on warp 1 rd=9, where warp 2 is independent
    present(1, 1, 1, 9, 0, 0, 0);
    tick();
    present(1, 1, 1, 9, 0, 0, 0);
    tick();
    tick();
    check("t3_waw_stall", 192'(last_ready), 192'(0));
    present(1, 2, 1, 9, 0, 0, 0);
    tick();
    check("t3_other_warp", 192'(last_ready), 192'(1));
    present(1, 1, 1, 9, 0, 0, 0);
    tick();
    check("t3_waw_again", 192'(last_ready), 192'(0));
    drive_wb(1, 1, 9, 1);
    tick();
    check("t3_waw_release", 192'(last_ready), 192'(1));
    drive_wb(0, 0, 0, 0);
    present(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Backpressure holds the output, and the stall counter ignores it
    present(1, 3, 1, 10, 1, 2, 0);
    tick();
    bus.out_ready = 1'b0;
    present(1, 3, 0, 0, 11, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_bp_ready", 192'(last_ready), 192'(0));
      check("t4_bp_rd", 192'(last_out_rd), 192'(10));
      check("t4_bp_stall", 192'(last_stall), 192'(6));
    end
    bus.out_ready = 1'b1;
    tick();
    check("t4_bp_release", 192'(last_ready), 192'(1));
    present(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("t4_second_rs1", 192'(last_out_rs1), 192'(11));

    // Same-cycle release and re-reserve of warp 0 rd=3
    present(1, 0, 1, 3, 0, 0, 0);
    tick();
    drive_wb(1, 0, 3, 1);
    tick();
    check("t5_set_clear", 192'(last_ready), 192'(1));
    drive_wb(0, 0, 0, 0);
    present(0, 0, 0, 0, 0, 0, 0);
    tick();
    present(1, 0, 0, 0, 3, 0, 0);
    tick();
    check("t5_set_wins", 192'(last_ready), 192'(0));
    present(0, 0, 0, 0, 0, 0, 0);
    drive_wb(1, 0, 3, 1);
    tick();
    drive_wb(0, 0, 0, 0);

    // rd=0 never reserves, then reset discards the held output and reservations
    present(1, 0, 1, 0, 0, 0, 0);
    tick();
    check("t6_rd0_accept", 192'(last_ready), 192'(1));
    present(1, 0, 0, 0, 0, 0, 0);
    tick();
    check("t6_rs0_no_stall", 192'(last_ready), 192'(1));
    present(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    tick();
    check("t6_pre_reset_valid", 192'(last_out_valid), 192'(1));
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t6_post_reset_valid", 192'(last_out_valid), 192'(0));
    check("t6_post_reset_stall", 192'(last_stall), 192'(0));
    present(1, 1, 0, 0, 9, 0, 0);
    tick();
    check("t6_inuse_cleared", 192'(last_ready), 192'(1));
    present(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
